// File: rtl/uart_rx_fifo.sv
// Loopback byte buffer: queues every byte strobed out of the UART receiver and
// hands them to the transmitter one data-ready strobe at a time, only while it is idle.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_busy,
    output logic              o_tx_dr,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic [7:0]        o_last_rx
);

    localparam int              TW        = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [TW-1:0]   TOUT_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RISE = 2'd2,
        WAIT_FALL = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     tcnt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              pop, push, drop;

    // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
    assign push = i_rx_done && ((count != FULL_CNT) || pop);
    assign drop = i_rx_done && !push;

    assign o_tx_dr = (state == SEND);
    assign o_count = count;
    assign o_empty = (count == '0);
    assign o_full  = (count == FULL_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == SEND)
                tcnt <= '0;
            else if (state == WAIT_RISE && !i_tx_busy)
                tcnt <= tcnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !i_tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND:      state_nxt = WAIT_RISE;
            WAIT_RISE: begin
                // A transmitter that never acknowledges costs us that byte, not the link.
                if (i_tx_busy)
                    state_nxt = WAIT_FALL;
                else if (tcnt == TOUT_LAST)
                    state_nxt = IDLE;
            end
            WAIT_FALL: begin
                if (!i_tx_busy)
                    state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= i_rx_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_tx_data  <= 8'h00;
            o_overflow <= 1'b0;
            o_last_rx  <= 8'h00;
        end else begin
            if (i_rx_done)
                o_last_rx <= i_rx_data;
            if (drop)
                o_overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                o_tx_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued at push time and
// a monitor pops and compares on every data-ready strobe.
module tb_uart_rx_fifo;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              tx_dr;
    logic [7:0]        tx_data;
    logic [ADDR_W:0]   count;
    logic              empty, full, overflow;
    logic [7:0]        last_rx;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_tx_busy(tx_busy), .o_tx_dr(tx_dr), .o_tx_data(tx_data), .o_count(count),
        .o_empty(empty), .o_full(full), .o_overflow(overflow), .o_last_rx(last_rx)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_last = 8'h00;
    int         strobes = 0;
    int         cyc = 0;
    int         last_strobe_cyc = 0;
    int         last_gap = 0;
    logic [7:0] last_sent = 8'h00;
    logic [7:0] last_tx = 8'h00;
    logic       prev_dr = 1'b0;

    typedef enum {TX_AUTO, TX_HOLD, TX_NEVER} tx_mode_t;
    tx_mode_t tx_mode = TX_AUTO;
    int       tx_delay = 1;
    int       tx_len = 10;
    int       pend = 0;
    int       blen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples just after each rising edge and pops the scoreboard on a strobe.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            last_tx = 8'h00;
            prev_dr = 1'b0;
        end else begin
            if (tx_dr) begin
                chk("strobe_not_back_to_back", {31'd0, prev_dr}, 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got data %0h expected no strobe", tx_data);
                end else begin
                    chk("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                strobes++;
                last_gap        = cyc - last_strobe_cyc;
                last_strobe_cyc = cyc;
                last_sent       = tx_data;
                last_tx         = tx_data;
            end else begin
                chk("tx_data_hold", {24'd0, tx_data}, {24'd0, last_tx});
            end
            prev_dr = tx_dr;
        end
    end

    // Transmitter model: after a strobe, raise busy tx_delay cycles later for tx_len cycles.
    initial forever begin
        @(negedge clk);
        case (tx_mode)
            TX_HOLD:  begin tx_busy = 1'b1; pend = 0; blen = 0; end
            TX_NEVER: begin tx_busy = 1'b0; pend = 0; blen = 0; end
            default: begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        tx_busy = 1'b1;
                        blen    = tx_len;
                    end
                end else if (blen > 0) begin
                    blen--;
                    if (blen == 0) tx_busy = 1'b0;
                end else begin
                    tx_busy = 1'b0;
                    if (tx_dr) pend = tx_delay;
                end
            end
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_mode(input tx_mode_t m);
        tx_mode = m;
        pend    = 0;
        blen    = 0;
        tx_busy = (m == TX_HOLD);
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        rx_done = 1'b0;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_last = 8'h00;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit accept);
        rx_done  = 1'b1;
        rx_data  = d;
        exp_last = d;
        if (accept) exp_q.push_back(d);
        else        exp_ovf = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (30) @(negedge clk);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_count"}, {27'd0, count}, exp_q.size());
        chk({tag, "_empty"}, {31'd0, empty}, {31'd0, exp_q.size() == 0});
        chk({tag, "_full"}, {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_last_rx"}, {24'd0, last_rx}, {24'd0, exp_last});
    endtask

    initial begin
        int         s0, t0;
        logic [7:0] d;
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;

        // Reset
        do_reset(2);
        chk("reset_tx_dr", {31'd0, tx_dr}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset_count", {27'd0, count}, 32'd0);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_last_rx", {24'd0, last_rx}, 32'd0);

        // Single echo
        tx_delay = 1; tx_len = 10;
        s0 = strobes; t0 = cyc;
        push_byte(8'h41, 1'b1);
        drain("echo_drain", 200);
        chk("echo_strobes", strobes - s0, 1);
        chk("echo_latency", last_strobe_cyc - t0, 2);
        chk("echo_data", {24'd0, last_sent}, 32'h41);
        chk_flags("echo");

        // Burst ordering
        set_mode(TX_HOLD);
        repeat (3) @(negedge clk);
        push_byte(8'h10, 1'b1);
        push_byte(8'h20, 1'b1);
        push_byte(8'h30, 1'b1);
        chk("burst_count", {27'd0, count}, 32'd3);
        s0 = strobes;
        tx_delay = 2; tx_len = 5;
        set_mode(TX_AUTO);
        drain("burst_drain", 300);
        chk("burst_strobes", strobes - s0, 3);

        // Full / overflow
        set_mode(TX_HOLD);
        repeat (3) @(negedge clk);
        for (int i = 0; i <= 16; i++) push_byte(8'(i), exp_q.size() < DEPTH);
        chk("full_full", {31'd0, full}, 32'd1);
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        chk("full_last_rx", {24'd0, last_rx}, 32'h10);
        s0 = strobes;
        set_mode(TX_AUTO);
        drain("full_drain", 2000);
        chk("full_strobes", strobes - s0, 16);
        chk("full_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Simultaneous push and pop while full
        set_mode(TX_HOLD);
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
        chk_flags("simul_pre");
        set_mode(TX_AUTO);
        push_byte(8'hAA, 1'b1);
        chk("simul_count", {27'd0, count}, 32'd16);
        chk("simul_overflow", {31'd0, overflow}, 32'd0);
        drain("simul_drain", 2000);
        chk("simul_last_sent", {24'd0, last_sent}, 32'hAA);

        // Timeout: the transmitter never acknowledges
        set_mode(TX_NEVER);
        s0 = strobes;
        push_byte(8'h5A, 1'b1);
        push_byte(8'hA5, 1'b1);
        drain("timeout_drain", 200);
        chk("timeout_strobes", strobes - s0, 2);
        chk("timeout_gap", {31'd0, (last_gap >= BUSY_TIMEOUT + 1) && (last_gap <= BUSY_TIMEOUT + 2)}, 32'd1);
        chk_flags("timeout");

        // Reset while waiting for busy to fall with bytes queued
        tx_delay = 1; tx_len = 40;
        set_mode(TX_AUTO);
        for (int i = 0; i < 6; i++) push_byte(8'(8'hC0 + i), 1'b1);
        repeat (2) @(negedge clk);
        chk("midrst_pre_count", {27'd0, count}, 32'd5);
        chk("midrst_busy", {31'd0, tx_busy}, 32'd1);
        do_reset(1);
        chk("midrst_count", {27'd0, count}, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_tx_dr", {31'd0, tx_dr}, 32'd0);
        s0 = strobes;
        repeat (60) @(negedge clk);
        chk("midrst_no_strobes", strobes - s0, 0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: begin
                        tx_delay = $urandom_range(1, 3);
                        tx_len   = $urandom_range(1, 8);
                        if (tx_mode != TX_AUTO) set_mode(TX_AUTO);
                    end
                    2:       set_mode(TX_HOLD);
                    default: set_mode(TX_NEVER);
                endcase
            end
            chk("rand_count", {27'd0, count}, exp_q.size());
            chk("rand_full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0 && (tx_mode == TX_HOLD || exp_q.size() < DEPTH)) begin
                push_byte(d, exp_q.size() < DEPTH);
                chk("rand_last_rx", {24'd0, last_rx}, {24'd0, d});
                chk("rand_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            end else begin
                @(negedge clk);
            end
        end
        tx_delay = 1; tx_len = 4;
        set_mode(TX_AUTO);
        drain("rand_drain", 2000);
        chk_flags("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte buffer between the UART receiver and the UART transmitter in the loopback path. It stores every byte strobed out of the receiver in a circular FIFO and dispatches bytes to the transmitter one at a time. Each dispatch is a single-cycle data-ready strobe that is issued only when the transmitter is idle. This means back-to-back host characters are echoed in order instead of being dropped while the transmitter is busy. The block also holds the most recently received byte for the seven-segment display path.

## Interface
- DEPTH, 16, FIFO entries; must be a power of two ≥ 2
- ADDR_W, 4, log2(DEPTH)
- BUSY_TIMEOUT, 16, cycles to wait for i_tx_busy to rise after a strobe before giving up
- i_clk  in  1  system clock; everything is on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_done  in  1  one-cycle strobe from the receiver; byte valid this cycle
- i_rx_data  in  8  received byte, sampled when i_rx_done=1
- i_tx_busy  in  1  transmitter busy flag
- o_tx_dr  out  1  one-cycle strobe to the transmitter data-ready input
- o_tx_data  out  8  byte to transmit; holds its value until the next dispatch
- o_count  out  ADDR_W+1  number of bytes currently stored (0..DEPTH)
- o_empty  out  1  o_count==0
- o_full  out  1  o_count==DEPTH
- o_overflow  out  1  sticky flag; set when a byte is dropped
- o_last_rx  out  8  last byte accepted or dropped; drives the display

## Operation
- **Storage:** circular buffer with ADDR_W-bit write and read pointers that wrap naturally from DEPTH-1 to 0. A separate count register tracks occupancy.
- **Push:** on i_rx_done=1 the byte is written at wr_ptr, wr_ptr increments and the count increments.
  - o_last_rx loads i_rx_data on every strobe, including dropped ones.
- **Push when full:** if i_rx_done=1, count==DEPTH and no pop occurs in the same cycle, the byte is dropped. o_overflow is set and the pointers and count are unchanged.
- **Simultaneous push and pop:** both happen and the count is unchanged. This holds when full: the pop frees a slot, so the push is accepted.
- **Pop:** only the dispatch FSM pops.
- **Dispatch FSM states:**
  - IDLE: if count>0 and i_tx_busy=0, go to SEND. On that edge o_tx_data loads mem[rd_ptr], rd_ptr increments and the count decrements.
  - SEND: o_tx_dr=1 for this one cycle only. Clear the timeout counter and go to WAIT_RISE.
  - WAIT_RISE: if i_tx_busy=1, go to WAIT_FALL. Otherwise increment the timeout counter; when it reaches BUSY_TIMEOUT-1, go to IDLE. The byte is treated as lost and is not re-queued.
  - WAIT_FALL: when i_tx_busy=0, go to IDLE.
- **Overflow flag:** o_overflow is cleared only by reset.
- **Reset:** applies to the FSM as well. Any state returns to IDLE, any byte in flight is abandoned and the buffer contents are discarded.

## Timing
- **Reset values:**
  - o_tx_dr=0, o_tx_data=0x00
  - o_count=0, o_empty=1, o_full=0
  - o_overflow=0, o_last_rx=0x00
  - FSM state IDLE, both pointers 0
- **Flag and data update:** o_count, o_empty, o_full and o_last_rx update on the edge that samples i_rx_done. They are valid the following cycle.
- **Push-to-strobe latency:** with the transmitter idle, a strobe at edge N into an empty FIFO gives count=1 after N. The FSM moves to SEND at N+1 and o_tx_dr=1 during the cycle after N+1, so the latency is 2 cycles.
- **o_tx_data stability:** o_tx_data is stable from the cycle o_tx_dr asserts until the next SEND.
- **Minimum dispatch spacing:** SEND + at least 1 WAIT_RISE cycle + at least 1 WAIT_FALL cycle + IDLE, i.e. 4 cycles. In practice the spacing is the transmitter frame time.
- **Strobe rule:** o_tx_dr is never high on two consecutive cycles.

## Test plan
- **Reset:** assert i_reset for 2 cycles → all outputs equal their reset values and o_empty=1.
- **Single echo:** push 0x41 with the transmitter model raising busy 1 cycle after the strobe for 10 cycles → o_tx_dr pulses once, o_tx_data=0x41 and o_count returns to 0.
- **Burst ordering:** push 0x10, 0x20, 0x30 on consecutive cycles while busy=1 → o_count=3. After busy falls, exactly three strobes follow, in order 0x10, 0x20, 0x30, each after a busy rise and fall.
- **Full/overflow:** hold busy=1 and push 17 bytes 0x00..0x10 → o_full=1, o_count=16, o_overflow=1 and o_last_rx=0x10. Drain → 0x00..0x0F out in order and o_overflow stays 1.
- **Simultaneous push/pop at full:** with the FIFO full, push 0xAA in the cycle the FSM pops → o_count stays 16, no overflow, and 0xAA is the last byte transmitted.
- **Timeout and reset mid-operation:**
  - Timeout: the transmitter model never raises busy → after BUSY_TIMEOUT cycles the FSM returns to IDLE and the next byte dispatches.
  - Reset mid-operation: assert i_reset while in WAIT_FALL with 5 bytes queued → the next cycle shows o_count=0 and state IDLE, and no further strobes occur.
